// File: rtl/elevator_ctrl_fsm.sv
// SCAN-policy elevator controller: turns datapath request/limit flags into
// one-cycle up/down strobes and a timed door-open level.
module elevator_ctrl_fsm #(
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       request_i,
  input  logic       request_j_gt_i,
  input  logic       request_j_lt_i,
  input  logic       at_top,
  input  logic       at_bottom,
  input  logic       door_hold,
  output logic       up,
  output logic       down,
  output logic       open,
  output logic       moving,
  output logic       dir_up,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DOOR_OPEN = 3'd1,
    MOVE_UP   = 3'd2,
    MOVE_DOWN = 3'd3,
    ARRIVE    = 3'd4
  } state_t;

  localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES) + 1;
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] ONE = TW'(1);
  // With single-cycle travel the strobe must already be high on the entry cycle.
  localparam logic FIRST_PULSE = (MOVE_CYCLES == 1);

  state_t        st;
  logic [TW-1:0] timer;

  logic   up_ok, dn_ok, ahead, behind;
  state_t mv_state;
  logic   mv_dir;
  logic   take;
  state_t tgt;

  assign state = st;

  // Direction part of the decision: continue ahead, otherwise reverse, otherwise rest.
  always_comb begin
    up_ok    = request_j_gt_i && !at_top;
    dn_ok    = request_j_lt_i && !at_bottom;
    ahead    = dir_up ? up_ok : dn_ok;
    behind   = dir_up ? dn_ok : up_ok;
    mv_state = IDLE;
    mv_dir   = dir_up;
    if (ahead) begin
      mv_state = dir_up ? MOVE_UP : MOVE_DOWN;
    end else if (behind) begin
      mv_state = dir_up ? MOVE_DOWN : MOVE_UP;
      mv_dir   = !dir_up;
    end
  end

  // Door exit skips the current-floor rule: open has already cleared that request.
  always_comb begin
    take = 1'b0;
    tgt  = IDLE;
    case (st)
      IDLE, ARRIVE: begin
        take = 1'b1;
        tgt  = request_i ? DOOR_OPEN : mv_state;
      end
      DOOR_OPEN: begin
        if (!door_hold && timer == DOOR_LAST) begin
          take = 1'b1;
          tgt  = mv_state;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      timer  <= '0;
      up     <= 1'b0;
      down   <= 1'b0;
      open   <= 1'b0;
      moving <= 1'b0;
      dir_up <= 1'b1;
    end else if (take) begin
      st     <= tgt;
      timer  <= '0;
      open   <= (tgt == DOOR_OPEN);
      moving <= (tgt == MOVE_UP) || (tgt == MOVE_DOWN);
      up     <= (tgt == MOVE_UP) && FIRST_PULSE;
      down   <= (tgt == MOVE_DOWN) && FIRST_PULSE;
      if (tgt == MOVE_UP || tgt == MOVE_DOWN) dir_up <= mv_dir;
    end else begin
      case (st)
        DOOR_OPEN: begin
          open  <= 1'b1;
          timer <= door_hold ? '0 : timer + ONE;
        end
        MOVE_UP: begin
          if (at_top || timer == MOVE_LAST) begin
            st     <= ARRIVE;
            timer  <= '0;
            up     <= 1'b0;
            moving <= 1'b0;
          end else begin
            timer <= timer + ONE;
            up    <= (timer + ONE == MOVE_LAST);
          end
        end
        MOVE_DOWN: begin
          if (at_bottom || timer == MOVE_LAST) begin
            st     <= ARRIVE;
            timer  <= '0;
            down   <= 1'b0;
            moving <= 1'b0;
          end else begin
            timer <= timer + ONE;
            down  <= (timer + ONE == MOVE_LAST);
          end
        end
        default: begin
          st     <= IDLE;
          timer  <= '0;
          up     <= 1'b0;
          down   <= 1'b0;
          open   <= 1'b0;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_fsm.sv
// Bench for elevator_ctrl_fsm: a cycle model of the SCAN rules plus a small
// floor/request datapath, with directed scenarios and a randomised run.
module tb_elevator_ctrl_fsm;
  localparam int MC = 8;
  localparam int DC = 16;
  localparam int NF = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic d_req_i, d_gt, d_lt, d_top, d_bot;
  logic door_hold;
  logic use_dp;

  int          floor;
  logic [NF-1:0] pending;
  logic        dp_gt, dp_lt;

  logic request_i, request_j_gt_i, request_j_lt_i, at_top, at_bottom;
  logic up, down, open, moving, dir_up;
  logic [2:0] state;

  always_comb begin
    dp_gt = 1'b0;
    dp_lt = 1'b0;
    for (int k = 0; k < NF; k++) begin
      if (pending[k] && k > floor) dp_gt = 1'b1;
      if (pending[k] && k < floor) dp_lt = 1'b1;
    end
  end

  assign request_i      = use_dp ? pending[floor] : d_req_i;
  assign request_j_gt_i = use_dp ? dp_gt : d_gt;
  assign request_j_lt_i = use_dp ? dp_lt : d_lt;
  assign at_top         = use_dp ? (floor == NF - 1) : d_top;
  assign at_bottom      = use_dp ? (floor == 0) : d_bot;

  elevator_ctrl_fsm #(.MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .request_i(request_i), .request_j_gt_i(request_j_gt_i), .request_j_lt_i(request_j_lt_i),
    .at_top(at_top), .at_bottom(at_bottom), .door_hold(door_hold),
    .up(up), .down(down), .open(open), .moving(moving), .dir_up(dir_up), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase code plus cycles still to spend in that phase after the current one.
  int m_state = 0;
  int m_left  = 0;
  bit m_dir   = 1'b1;

  logic prev_up = 1'b0, prev_down = 1'b0, prev_open_dp = 1'b0;
  logic       log_en = 1'b0;
  logic [7:0] visit_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void decide(input bit use_i);
    bit up_ok, dn_ok;
    up_ok = request_j_gt_i && !at_top;
    dn_ok = request_j_lt_i && !at_bottom;
    if (use_i && request_i) begin
      m_state = 1; m_left = DC - 1;
    end else if (m_dir ? up_ok : dn_ok) begin
      m_state = m_dir ? 2 : 3; m_left = MC - 1;
    end else if (m_dir ? dn_ok : up_ok) begin
      m_dir = !m_dir; m_state = m_dir ? 2 : 3; m_left = MC - 1;
    end else begin
      m_state = 0;
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_state = 0; m_left = 0; m_dir = 1'b1;
    end else begin
      case (m_state)
        0, 4: decide(1'b1);
        1: begin
          if (door_hold) m_left = DC - 1;
          else if (m_left == 0) decide(1'b0);
          else m_left--;
        end
        2: if (at_top || m_left == 0) m_state = 4; else m_left--;
        3: if (at_bottom || m_left == 0) m_state = 4; else m_left--;
        default: m_state = 0;
      endcase
    end
  endfunction

  task automatic compare();
    chk("state", int'(state), m_state);
    chk("up", int'(up), int'(m_state == 2 && m_left == 0));
    chk("down", int'(down), int'(m_state == 3 && m_left == 0));
    chk("open", int'(open), int'(m_state == 1));
    chk("moving", int'(moving), int'(m_state == 2 || m_state == 3));
    chk("dir_up", int'(dir_up), int'(m_dir));
    chk("strobe_exclusive", int'(up) + int'(down) + int'(open) <= 1 ? 1 : 0, 1);
    chk("strobe_back_to_back", int'((up && prev_up) || (down && prev_down)), 0);
    chk("open_while_moving", int'(open && moving), 0);
    prev_up   = up;
    prev_down = down;
  endtask

  // Datapath reaction, applied half a cycle after each edge.
  task automatic dp_step();
    if (use_dp) begin
      if (up && floor < NF - 1) floor++;
      if (down && floor > 0) floor--;
      if (open) begin
        if (!prev_open_dp && log_en) visit_q.push_back(8'(floor));
        pending[floor] = 1'b0;
      end
    end
    prev_open_dp = open;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
    dp_step();
  endtask

  task automatic clear_direct();
    d_req_i = 0; d_gt = 0; d_lt = 0; d_top = 0; d_bot = 0; door_hold = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, k, n_up, n_mv;
    rst = 1'b1; use_dp = 1'b0; floor = 0; pending = '0;
    clear_direct();
    d_bot = 1'b1;
    do_reset();
    chk("reset_state", int'(state), 0);
    chk("reset_dir", int'(dir_up), 1);

    // Request above from floor 0: travel, single up strobe, arrive, rest.
    d_gt = 1'b1;
    tick();
    chk("t2_enter_move_up", int'(state), 2);
    k = 0;
    while (!up && k < 50) begin k++; tick(); end
    chk("t2_up_after_entry", k, MC - 1);
    d_gt = 1'b0; d_bot = 1'b0;
    tick();
    chk("t2_arrive", int'(state), 4);
    chk("t2_up_single", int'(up), 0);
    tick();
    chk("t2_back_idle", int'(state), 0);

    // Door dwell, plain and with a hold press at cycle 10.
    d_req_i = 1'b1;
    tick();
    d_req_i = 1'b0;
    n = 0;
    while (open && n < 100) begin n++; tick(); end
    chk("t3_open_cycles", n, DC);
    d_req_i = 1'b1;
    tick();
    d_req_i = 1'b0;
    n = 0;
    while (open && n < 100) begin door_hold = (n == 10); n++; tick(); end
    door_hold = 1'b0;
    chk("t3_open_with_hold", n, 27);

    // Reset while travelling down after a reversal.
    d_lt = 1'b1;
    tick();
    chk("t1_move_down", int'(state), 3);
    chk("t1_dir_down", int'(dir_up), 0);
    tick(); tick(); tick();
    d_lt = 1'b0;
    do_reset();
    chk("t1_state", int'(state), 0);
    chk("t1_strobes", int'(up) + int'(down) + int'(open) + int'(moving), 0);
    chk("t1_dir", int'(dir_up), 1);

    // Top limit blocks upward travel; a limit hit mid-move aborts without a strobe.
    d_top = 1'b1; d_gt = 1'b1;
    n_up = 0; n_mv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (up) n_up++;
      if (moving) n_mv++;
    end
    chk("t5_no_up", n_up, 0);
    chk("t5_no_move", n_mv, 0);
    chk("t5_idle", int'(state), 0);
    d_top = 1'b0;
    tick();
    chk("t5_move_up", int'(state), 2);
    tick(); tick();
    if (up) n_up++;
    d_top = 1'b1;
    tick();
    if (up) n_up++;
    chk("t5_abort_arrive", int'(state), 4);
    chk("t5_abort_no_up", n_up, 0);
    d_gt = 1'b0;
    tick();
    chk("t5_abort_idle", int'(state), 0);

    // SCAN order from floor 2 with stops at 0, 3 and 5.
    clear_direct();
    do_reset();
    floor = 2;
    pending = '0;
    pending[0] = 1'b1; pending[3] = 1'b1; pending[5] = 1'b1;
    visit_q.delete();
    log_en = 1'b1;
    use_dp = 1'b1;
    n = 0;
    while ((pending != '0 || state != 3'd0) && n < 1000) begin n++; tick(); end
    log_en = 1'b0;
    exp_q = '{8'd3, 8'd5, 8'd0};
    chk("t4_served", int'(pending == '0), 1);
    chk("t4_stops", visit_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < visit_q.size(); i++)
      chk("t4_stop_floor", int'(visit_q[i]), int'(exp_q[i]));
    chk("t4_final_dir", int'(dir_up), 0);
    chk("t4_final_floor", floor, 0);

    // Random requests and door holds; every request must eventually be served.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) pending[$urandom_range(0, NF - 1)] = 1'b1;
      door_hold = ($urandom_range(0, 49) == 0);
      tick();
    end
    door_hold = 1'b0;
    n = 0;
    while ((pending != '0 || state != 3'd0) && n < 3000) begin n++; tick(); end
    chk("t6_all_served", int'(pending == '0), 1);
    chk("t6_idle", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
